alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle issue controller for the ALU. Accepts one operation (opcode + RA/RB)
//  per valid/ready handshake, drives the ALU's registered operand/op inputs, waits the
//  op's latency, then captures ResultHi/ResultLo into the Z_hi/Z_lo holding registers.
//  Sits between the control unit and the ALU, giving the control unit a uniform handshake.
// PARAMETERS
//  MUL_CYCLES  33  cycles from ALU op issue to valid MUL result (>=1, <2**CNT_W)
//  DIV_CYCLES  34  cycles from ALU op issue to valid DIV result (>=1, <2**CNT_W)
//  CNT_W       6   latency counter width
// PORTS
//  clock      in   1   system clock, rising edge
//  clear      in   1   asynchronous, active-low reset
//  start      in   1   request valid; accepted on the rising edge where start && ready
//  op         in   5   opcode: ADD=3 SUB=4 AND=5 OR=6 ROR=7 ROL=8 SHR=9 SHRA=10 SHL=11
//                      ADDI=12 ANDI=13 ORI=14 DIV=15 MUL=16 NEG=17 NOT=18
//  ra, rb     in   32  operands, sampled only at acceptance
//  ready      out  1   high in IDLE (combinational from state)
//  busy       out  1   high in EXEC
//  done       out  1   one-cycle pulse; Z_hi/Z_lo (or err) valid in the same cycle
//  err        out  1   valid with done: 1 = illegal opcode, Z unchanged
//  alu_RA     out  32  registered operand A to ALU
//  alu_RB     out  32  registered operand B to ALU
//  alu_Op     out  5   registered opcode to ALU; 0 whenever not in EXEC
//  alu_hi     in   32  ALU ResultHi
//  alu_lo     in   32  ALU ResultLo
//  Z_hi, Z_lo out  32  result holding registers
// BEHAVIOUR
//  - Reset (clear=0, async): state=IDLE, all outputs/regs 0, counter 0.
//  - States: IDLE, EXEC. IDLE--accept legal op-->EXEC; EXEC--count==1-->IDLE.
//  - Accept at edge k: latch alu_RA=ra, alu_RB=rb, alu_Op=op; counter loaded with
//    L = MUL_CYCLES (MUL), DIV_CYCLES (DIV), 1 (all other legal ops).
//  - EXEC: counter decrements each edge. On the edge where counter==1: Z_hi<=alu_hi,
//    Z_lo<=alu_lo, done<=1, err<=0, alu_Op<=0, state<=IDLE. So Z/done valid after edge k+L.
//  - Non-MUL ops: Z_hi captured as returned by ALU (0 for 32-bit ops).
//  - Illegal op (0-2, 19-31): no EXEC; at edge k done<=1, err<=1, Z held, alu_* unchanged.
//  - done/err clear on the next edge unless set again; ready=1 during done cycle, so a
//    back-to-back start is accepted on the edge after done rises (no bubble).
//  - start while busy: ignored, no queueing; ra/rb/op changes during EXEC have no effect.
//  - Reset mid-EXEC: op aborted, no done, Z returns to 0.
//  - Counter never wraps: L>=1 guaranteed by parameter rules.
// CONFIGURATION
//  ALU_SEQ_DIV_EN defined: DIV (15) legal, latency DIV_CYCLES.
//  Not defined: DIV treated as illegal (done+err at edge k, never issued to ALU);
//  DIV_CYCLES unused.
// TESTING
//  1 ADD ra=5 rb=7 start at edge k -> done at k+1, Z_lo=12, Z_hi=0, err=0, alu_Op=0 after.
//  2 MUL ra=0xFFFFFFFF rb=2 -> busy for 33 cycles, done at k+33, Z_hi=0xFFFFFFFF,
//    Z_lo=0xFFFFFFFE.
//  3 start ADD during MUL EXEC (cycle k+5) -> ignored, ready=0, MUL result unaffected;
//    ADD issued right after done is accepted next edge, done one edge later.
//  4 clear=0 at k+10 of MUL -> all outputs 0 immediately, no done; new NOT rb=0 after
//    release -> Z_lo=0xFFFFFFFF.
//  5 op=0 and op=31 -> done+err=1 at k, Z unchanged, alu_Op stays 0.
//  6 DIV ra=100 rb=7: with ALU_SEQ_DIV_EN -> done at k+34, err=0; without -> done+err at k.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller between the control unit and the ALU.
// Optional feature: define ALU_SEQ_DIV_EN to make DIV legal (latency DIV_CYCLES).
module alu_sequencer #(
    parameter int MUL_CYCLES = 33,
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] alu_RA,
    output logic [31:0] alu_RB,
    output logic [4:0]  alu_Op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic [31:0] Z_hi,
    output logic [31:0] Z_lo
);

    localparam logic [4:0] OP_FIRST = 5'd3;
    localparam logic [4:0] OP_LAST  = 5'd18;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept, issue, finish;

    function automatic logic is_legal(input logic [4:0] o);
`ifdef ALU_SEQ_DIV_EN
        return (o >= OP_FIRST) && (o <= OP_LAST);
`else
        return (o >= OP_FIRST) && (o <= OP_LAST) && (o != OP_DIV);
`endif
    endfunction

    function automatic logic [CNT_W-1:0] latency(input logic [4:0] o);
        if (o == OP_MUL) return CNT_W'(MUL_CYCLES);
        if (o == OP_DIV) return CNT_W'(DIV_CYCLES);
        return CNT_W'(1);
    endfunction

    assign accept = start && ready;
    assign issue  = accept && is_legal(op);
    assign finish = (state == EXEC) && (cnt == CNT_W'(1));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue)  state_next = EXEC;
            EXEC: if (finish) state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        busy  = (state == EXEC);
    end

    // Issue latch, latency countdown and result capture; done/err are single-cycle pulses.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            alu_RA <= '0;
            alu_RB <= '0;
            alu_Op <= '0;
            Z_hi   <= '0;
            Z_lo   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (issue) begin
                alu_RA <= ra;
                alu_RB <= rb;
                alu_Op <= op;
                cnt    <= latency(op);
            end else if (accept) begin
                done <= 1'b1;
                err  <= 1'b1;
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
                if (finish) begin
                    Z_hi   <= alu_hi;
                    Z_lo   <= alu_lo;
                    done   <= 1'b1;
                    alu_Op <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a latency-accurate ALU model.
// Expectations follow ALU_SEQ_DIV_EN when defined at build time.
module tb_alu_sequencer;

    localparam int MUL_CYCLES = 33;
    localparam int DIV_CYCLES = 34;
    localparam int CNT_W      = 6;

    logic        clock, clear, start;
    logic [4:0]  op;
    logic [31:0] ra, rb;
    logic        ready, busy, done, err;
    logic [31:0] alu_RA, alu_RB;
    logic [4:0]  alu_Op;
    logic [31:0] alu_hi, alu_lo;
    logic [31:0] Z_hi, Z_lo;

    int checks = 0;
    int errors = 0;
    int age;
    logic [31:0] exp_hi, exp_lo, last_ra, last_rb;

    alu_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb),
        .ready(ready), .busy(busy), .done(done), .err(err),
        .alu_RA(alu_RA), .alu_RB(alu_RB), .alu_Op(alu_Op),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .Z_hi(Z_hi), .Z_lo(Z_lo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic ref_legal(input logic [4:0] o);
`ifdef ALU_SEQ_DIV_EN
        return (o >= 5'd3) && (o <= 5'd18);
`else
        return (o >= 5'd3) && (o <= 5'd18) && (o != 5'd15);
`endif
    endfunction

    function automatic int ref_lat(input logic [4:0] o);
        if (o == 5'd16) return MUL_CYCLES;
        if (o == 5'd15) return DIV_CYCLES;
        return 1;
    endfunction

    // Behavioural ALU: {hi, lo}
    function automatic logic [63:0] alu_f(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] dbl, tmp;
        logic signed [63:0] prod;
        int sh;
        sh  = int'(b[4:0]);
        dbl = {a, a};
        case (o)
            5'd3, 5'd12: return {32'd0, a + b};
            5'd4:        return {32'd0, a - b};
            5'd5, 5'd13: return {32'd0, a & b};
            5'd6, 5'd14: return {32'd0, a | b};
            5'd7: begin tmp = dbl >> sh; return {32'd0, tmp[31:0]}; end
            5'd8: begin tmp = dbl << sh; return {32'd0, tmp[63:32]}; end
            5'd9:        return {32'd0, a >> sh};
            5'd10:       return {32'd0, 32'($signed(a) >>> sh)};
            5'd11:       return {32'd0, a << sh};
            5'd15:       return (b == 0) ? 64'd0 : {a % b, a / b};
            5'd16: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return prod;
            end
            5'd17:       return {32'd0, -b};
            5'd18:       return {32'd0, ~b};
            default:     return 64'd0;
        endcase
    endfunction

    // ALU result becomes valid only after the op's full latency; garbage before that.
    always @(posedge clock or negedge clear) begin
        if (!clear) age <= 0;
        else        age <= (alu_Op == 5'd0) ? 0 : age + 1;
    end
    assign {alu_hi, alu_lo} = (alu_Op != 5'd0 && age >= ref_lat(alu_Op) - 1)
                              ? alu_f(alu_Op, alu_RA, alu_RB) : 64'hDEADBEEF_BAD0C0DE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request at the current cycle (mid-cycle) and follow it to completion.
    task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int ign);
        logic [63:0] r;
        int n;
        r = alu_f(o, a, b);
        start = 1'b1; op = o; ra = a; rb = b;
        @(posedge clock); #1;
        start = 1'b0; op = 5'($urandom); ra = $urandom; rb = $urandom;
        if (ref_legal(o)) begin
            check("issue_busy", busy, 1);
            check("issue_ready", ready, 0);
            check("issue_op", alu_Op, o);
            check("issue_ra", alu_RA, a);
            check("issue_rb", alu_RB, b);
            check("issue_done_clr", done, 0);
            n = 0;
            while (!done && n < 200) begin
                if (n + 1 == ign) begin
                    check("busy_ready", ready, 0);
                    start = 1'b1; op = 5'd3; ra = $urandom; rb = $urandom;
                end
                @(posedge clock); #1;
                start = 1'b0;
                n++;
            end
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            last_ra = a;
            last_rb = b;
            check("latency", n, ref_lat(o));
            check("z_hi", Z_hi, exp_hi);
            check("z_lo", Z_lo, exp_lo);
            check("done_err", err, 0);
            check("op_cleared", alu_Op, 0);
            check("done_ready", ready, 1);
            check("done_busy", busy, 0);
        end else begin
            check("ill_done", done, 1);
            check("ill_err", err, 1);
            check("ill_z_hi", Z_hi, exp_hi);
            check("ill_z_lo", Z_lo, exp_lo);
            check("ill_op", alu_Op, 0);
            check("ill_busy", busy, 0);
            check("ill_ra", alu_RA, last_ra);
            check("ill_rb", alu_RB, last_rb);
        end
    endtask

    initial begin
        logic [4:0] ro;
        clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0;
        exp_hi = '0; exp_lo = '0; last_ra = '0; last_rb = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_z", {Z_hi, Z_lo}, 0);
        check("rst_alu", {alu_RA, alu_RB, alu_Op}, 0);
        clear = 1'b1;
        @(posedge clock); #1;

        do_op(5'd3, 32'd5, 32'd7, 0);
        check("t1_lo", Z_lo, 32'd12);
        check("t1_hi", Z_hi, 32'd0);

        do_op(5'd16, 32'hFFFFFFFF, 32'd2, 0);
        check("t2_hi", Z_hi, 32'hFFFFFFFF);
        check("t2_lo", Z_lo, 32'hFFFFFFFE);

        do_op(5'd16, 32'h12345678, 32'h9ABCDEF0, 5);
        do_op(5'd3, 32'd40, 32'd2, 0);
        check("t3_lo", Z_lo, 32'd42);

        do_op(5'd0, 32'd1, 32'd2, 0);
        do_op(5'd31, 32'd3, 32'd4, 0);
        @(posedge clock); #1;
        check("ill_done_clr", done, 0);
        check("ill_err_clr", err, 0);

        do_op(5'd15, 32'd100, 32'd7, 0);
`ifdef ALU_SEQ_DIV_EN
        check("t6_lo", Z_lo, 32'd14);
        check("t6_hi", Z_hi, 32'd2);
`else
        check("t6_err", err, 1);
`endif

        // Reset in the middle of a MUL
        start = 1'b1; op = 5'd16; ra = 32'd9; rb = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_z", {Z_hi, Z_lo}, 0);
        check("mid_rst_alu", {alu_RA, alu_RB, alu_Op}, 0);
        exp_hi = '0; exp_lo = '0; last_ra = '0; last_rb = '0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("no_done_after_rst", done, 0);
        check("no_z_after_rst", {Z_hi, Z_lo}, 0);
        do_op(5'd18, 32'd0, 32'd0, 0);
        check("t4_lo", Z_lo, 32'hFFFFFFFF);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) ro = 5'($urandom_range(0, 31));
            else                           ro = 5'($urandom_range(3, 18));
            do_op(ro, $urandom, $urandom, int'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
